// File: rtl/count_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | count_sequencer                                                            |
// | Programmable up/down interval counter with preload, hold and auto-reload.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module count_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             STOP,
   input  logic             HOLD,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   input  logic [WIDTH-1:0] LIMIT,
   input  logic             MODE,
   input  logic             UP_DN,
   output logic [WIDTH-1:0] Q,
   output logic             BUSY,
   output logic             DONE,
   output logic [1:0]       STATE
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10
   } state_t;

   state_t           state_r, state_nxt;
   logic [WIDTH-1:0] q_r, q_nxt;
   logic [WIDTH-1:0] limit_r, limit_nxt;
   logic [WIDTH-1:0] reload_r, reload_nxt;
   logic             mode_r, mode_nxt;
   logic             dir_r, dir_nxt;
   logic             done_r, done_nxt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r  <= S_IDLE;
         q_r      <= '0;
         limit_r  <= '0;
         reload_r <= '0;
         mode_r   <= 1'b0;
         dir_r    <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt;
         q_r      <= q_nxt;
         limit_r  <= limit_nxt;
         reload_r <= reload_nxt;
         mode_r   <= mode_nxt;
         dir_r    <= dir_nxt;
         done_r   <= done_nxt;
      end
   end

   always_comb begin
      state_nxt  = state_r;
      q_nxt      = q_r;
      limit_nxt  = limit_r;
      reload_nxt = reload_r;
      mode_nxt   = mode_r;
      dir_nxt    = dir_r;
      done_nxt   = 1'b0;

      case (state_r)
         S_IDLE: begin
            // HOLD has no meaning before a run is started
            if (STOP) begin
               state_nxt = S_IDLE;
            end else if (LOAD) begin
               q_nxt = LOAD_VAL;
            end else if (START) begin
               limit_nxt  = LIMIT;
               mode_nxt   = MODE;
               dir_nxt    = UP_DN;
               reload_nxt = LOAD_VAL;
               state_nxt  = S_RUN;
            end
         end
         S_RUN: begin
            if (STOP) begin
               state_nxt = S_IDLE;
            end else if (HOLD) begin
               state_nxt = S_PAUSE;
            end else if (q_r == limit_r) begin
               // terminal is tested on the pre-step value, so a run that
               // starts on its limit fires with zero steps taken
               done_nxt = 1'b1;
               if (mode_r) begin
                  q_nxt = reload_r;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else if (dir_r) begin
               q_nxt = q_r + WIDTH'(1);
            end else begin
               q_nxt = q_r - WIDTH'(1);
            end
         end
         S_PAUSE: begin
            if (STOP) begin
               state_nxt = S_IDLE;
            end else if (LOAD) begin
               q_nxt = LOAD_VAL;
            end else if (!HOLD) begin
               state_nxt = S_RUN;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign Q     = q_r;
   assign DONE  = done_r;
   assign STATE = state_r;
   assign BUSY  = (state_r == S_RUN) || (state_r == S_PAUSE);

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_count_sequencer                                                         |
// | Scoreboard bench: directed scenarios then randomized traffic vs a model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_count_sequencer;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic         CLK = 1'b0;
   logic         RST;
   logic         START, STOP, HOLD, LOAD, MODE, UP_DN;
   logic [W-1:0] LOAD_VAL, LIMIT;
   logic [W-1:0] Q;
   logic         BUSY, DONE;
   logic [1:0]   STATE;

   count_sequencer #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .HOLD(HOLD),
      .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .LIMIT(LIMIT), .MODE(MODE),
      .UP_DN(UP_DN), .Q(Q), .BUSY(BUSY), .DONE(DONE), .STATE(STATE)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [W-1:0] q;
      logic         busy;
      logic         done;
      logic [1:0]   state;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   started  = 0;

   // reference model: a run is either inactive, active, or active-but-frozen
   int m_q, m_lim, m_reload;
   bit m_active, m_frozen, m_autoreload, m_up, m_done;

   function automatic void model_reset();
      m_q = 0; m_lim = 0; m_reload = 0;
      m_active = 0; m_frozen = 0; m_autoreload = 0; m_up = 0; m_done = 0;
   endfunction

   function automatic void model_edge();
      m_done = 0;
      if (!m_active) begin
         if (STOP) begin
         end else if (LOAD) begin
            m_q = int'(LOAD_VAL);
         end else if (START) begin
            m_lim = int'(LIMIT); m_reload = int'(LOAD_VAL);
            m_autoreload = MODE; m_up = UP_DN;
            m_active = 1; m_frozen = 0;
         end
      end else if (STOP) begin
         m_active = 0; m_frozen = 0;
      end else if (m_frozen) begin
         if (LOAD) m_q = int'(LOAD_VAL);
         else if (!HOLD) m_frozen = 0;
      end else if (HOLD) begin
         m_frozen = 1;
      end else if (m_q == m_lim) begin
         m_done = 1;
         if (m_autoreload) m_q = m_reload;
         else m_active = 0;
      end else begin
         m_q = m_up ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
      end
   endfunction

   function automatic void push_exp();
      exp_t e;
      e.q     = W'(m_q);
      e.busy  = m_active;
      e.done  = m_done;
      e.state = !m_active ? 2'd0 : (m_frozen ? 2'd2 : 2'd1);
      exp_q.push_back(e);
   endfunction

   // one clock: inputs already set, model predicts the edge, wait for next negedge
   task automatic tick();
      if (RST) model_reset();
      else model_edge();
      push_exp();
      @(negedge CLK);
   endtask

   task automatic clr();
      START = 0; STOP = 0; LOAD = 0;
   endtask

   task automatic async_reset();
      #2;
      model_reset();
      push_exp();
      RST = 1;
      push_exp();
      @(negedge CLK);
      RST = 0;
   endtask

   // monitor: every output update point pops one expectation
   initial begin
      exp_t e, a;
      wait (started);
      forever begin
         @(posedge CLK or posedge RST);
         #1;
         a.q = Q; a.busy = BUSY; a.done = DONE; a.state = STATE;
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_output t=%0t actual q=%0d busy=%0b done=%0b state=%0d, no expectation queued",
                     $time, a.q, a.busy, a.done, a.state);
         end else begin
            e = exp_q.pop_front();
            if (a === e) n_pass++;
            else
               $display("FAIL outputs t=%0t actual q=%0d busy=%0b done=%0b state=%0d required q=%0d busy=%0b done=%0b state=%0d",
                        $time, a.q, a.busy, a.done, a.state, e.q, e.busy, e.done, e.state);
         end
      end
   end

   initial begin
      RST = 1; HOLD = 0; MODE = 0; UP_DN = 0; LOAD_VAL = '0; LIMIT = '0;
      clr();
      model_reset();
      repeat (2) @(negedge CLK);
      started = 1;
      push_exp();                 // reset state seen on an edge while RST high
      @(negedge CLK);
      RST = 0;

      // 1: one-shot up 3..7
      LOAD = 1; LOAD_VAL = 3; tick(); clr();
      START = 1; LIMIT = 7; UP_DN = 1; MODE = 0; tick(); clr();
      repeat (6) tick();

      // 2: auto-reload 2..5, stop at Q=4
      LOAD = 1; LOAD_VAL = 2; tick(); clr();
      START = 1; LIMIT = 5; UP_DN = 1; MODE = 1; tick(); clr();
      LOAD_VAL = 9; LIMIT = 0; MODE = 0; UP_DN = 0;   // latched values must not move
      repeat (10) tick();
      STOP = 1; tick(); clr();
      repeat (2) tick();

      // 3: down-count through wrap 1,0,15,14
      LOAD = 1; LOAD_VAL = 1; tick(); clr();
      START = 1; LIMIT = 14; UP_DN = 0; MODE = 0; tick(); clr();
      repeat (5) tick();

      // 4: hold at 5, load 8 while paused, release to 9
      LOAD = 1; LOAD_VAL = 0; tick(); clr();
      START = 1; LIMIT = 9; UP_DN = 1; MODE = 0; tick(); clr();
      repeat (5) tick();
      HOLD = 1; repeat (3) tick();
      LOAD = 1; LOAD_VAL = 8; tick(); clr();
      HOLD = 0; repeat (4) tick();

      // 5: START+STOP in idle, then start on limit 0
      START = 1; STOP = 1; LIMIT = 3; tick(); clr();
      LOAD = 1; LOAD_VAL = 0; tick(); clr();
      START = 1; LIMIT = 0; MODE = 0; tick(); clr();
      repeat (2) tick();

      // auto-reload with reload == limit pulses every cycle
      LOAD = 1; LOAD_VAL = 6; tick(); clr();
      START = 1; LIMIT = 6; MODE = 1; tick(); clr();
      repeat (4) tick();
      STOP = 1; tick(); clr();

      // 6: async reset mid-run at Q=6
      LOAD = 1; LOAD_VAL = 4; tick(); clr();
      START = 1; LIMIT = 12; UP_DN = 1; MODE = 0; tick(); clr();
      repeat (2) tick();
      async_reset();
      repeat (3) tick();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         START    = ($urandom_range(0, 3) == 0);
         STOP     = ($urandom_range(0, 24) == 0);
         LOAD     = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 9) == 0) HOLD = ~HOLD;
         LOAD_VAL = W'($urandom);
         LIMIT    = W'($urandom);
         MODE     = 1'($urandom);
         UP_DN    = 1'($urandom);
         if ($urandom_range(0, 399) == 0) async_reset();
         else tick();
      end
      clr(); HOLD = 0;
      tick();

      #2;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain actual %0d left, required 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
